activity_led_bank: RTL and testbench

//   Multi-channel activity indicator: each channel turns a one-cycle (or longer) activity trigger

---
 rtl/activity_led_pkg.sv | 13 +
 rtl/activity_led_channel.sv | 99 +++++++++
 rtl/activity_led_bank.sv | 62 ++++++
 tb/tb_activity_led_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/activity_led_pkg.sv
// Shared definitions for the activity LED bank: per-channel FSM state encoding
// and the PWM counter width used when ACTIVITY_LED_PWM_EN is defined.
package activity_led_pkg;

    localparam int PWM_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } led_state_e;

endpackage

// File: rtl/activity_led_channel.sv
// One LED channel: turns a trigger into a burst of BLINK_COUNT on/off blinks,
// with a single sticky pending flag so retriggers during a burst queue one more burst.
module activity_led_channel
    import activity_led_pkg::*;
#(
    parameter int PHASE_CYCLES = 2**24,
    parameter int BLINK_COUNT  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_trigger,
    output logic o_on,
    output logic o_busy
);

    localparam int CNT_W = $clog2(PHASE_CYCLES);
    localparam int BL_W  = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BL_W-1:0]  BL_INIT  = BL_W'(BLINK_COUNT - 1);
    localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);

    led_state_e       r_state;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [BL_W-1:0]  r_blinks_left;
    logic             r_pending;
    logic             w_phase_end;

    assign w_phase_end = (r_phase_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_phase_cnt   <= '0;
            r_blinks_left <= '0;
            r_pending     <= 1'b0;
        end else if (!i_en) begin
            r_state       <= ST_IDLE;
            r_phase_cnt   <= '0;
            r_blinks_left <= '0;
            r_pending     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_trigger) begin
                        r_state       <= ST_ON;
                        r_phase_cnt   <= '0;
                        r_blinks_left <= BL_INIT;
                        r_pending     <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (i_trigger) begin
                        r_pending <= 1'b1;
                    end
                    if (w_phase_end) begin
                        r_state     <= ST_OFF;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + CNT_ONE;
                    end
                end
                ST_OFF: begin
                    if (w_phase_end) begin
                        r_phase_cnt <= '0;
                        if (r_blinks_left != '0) begin
                            r_state       <= ST_ON;
                            r_blinks_left <= r_blinks_left - BL_ONE;
                            if (i_trigger) begin
                                r_pending <= 1'b1;
                            end
                        // A trigger on the last OFF cycle chains straight into the next burst.
                        end else if (r_pending || i_trigger) begin
                            r_state       <= ST_ON;
                            r_blinks_left <= BL_INIT;
                            r_pending     <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt + CNT_ONE;
                        if (i_trigger) begin
                            r_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_on   = (r_state == ST_ON);
    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/activity_led_bank.sv
// Multi-channel activity LED bank. Define ACTIVITY_LED_PWM_EN to add the
// brightness input and a shared free-running PWM counter gating the lit phase.
module activity_led_bank
    import activity_led_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int PHASE_CYCLES   = 2**24,
    parameter int BLINK_COUNT    = 2,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_CH-1:0]    trigger,
`ifdef ACTIVITY_LED_PWM_EN
    input  logic [PWM_WIDTH-1:0] brightness,
`endif
    output logic [NUM_CH-1:0]    led_out,
    output logic [NUM_CH-1:0]    busy
);

    localparam logic LED_POL = (LED_ACTIVE_LOW != 0);

    logic [NUM_CH-1:0] w_on;
    logic [NUM_CH-1:0] w_lit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        activity_led_channel #(
            .PHASE_CYCLES (PHASE_CYCLES),
            .BLINK_COUNT  (BLINK_COUNT)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (en),
            .i_trigger (trigger[g]),
            .o_on      (w_on[g]),
            .o_busy    (busy[g])
        );
    end

`ifdef ACTIVITY_LED_PWM_EN
    logic [PWM_WIDTH-1:0] r_pwm_cnt;
    logic                 w_pwm_gate;

    // Free-running and shared, so every channel dims in phase with the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
        end
    end

    assign w_pwm_gate = (r_pwm_cnt < brightness);
    assign w_lit      = w_on & {NUM_CH{w_pwm_gate}};
`else
    assign w_lit = w_on;
`endif

    assign led_out = w_lit ^ {NUM_CH{LED_POL}};

endmodule

// File: tb/tb_activity_led_bank.sv
// Directed self-checking bench for activity_led_bank (NUM_CH=2, PHASE_CYCLES=4,
// BLINK_COUNT=2); a second instance checks LED_ACTIVE_LOW=1 polarity.
module tb_activity_led_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] trigger;
    logic [1:0] ledA;
    logic [1:0] busyA;
    logic [1:0] ledB;
    logic [1:0] busyB;
`ifdef ACTIVITY_LED_PWM_EN
    logic [7:0] brightness;
    initial brightness = 8'd255;
`endif

    int vectors;
    int miscompares;

    activity_led_bank #(
        .NUM_CH(2), .PHASE_CYCLES(4), .BLINK_COUNT(2), .LED_ACTIVE_LOW(0)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .trigger(trigger),
`ifdef ACTIVITY_LED_PWM_EN
        .brightness(brightness),
`endif
        .led_out(ledA), .busy(busyA)
    );

    activity_led_bank #(
        .NUM_CH(2), .PHASE_CYCLES(4), .BLINK_COUNT(2), .LED_ACTIVE_LOW(1)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .en(en), .trigger(trigger),
`ifdef ACTIVITY_LED_PWM_EN
        .brightness(brightness),
`endif
        .led_out(ledB), .busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] trg, input logic enable);
        trigger = trg;
        en      = enable;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [0:17] pat2;
        logic [0:33] pat3;
        logic        bit1;
        vectors     = 0;
        miscompares = 0;
        pat2 = 18'b0_1111_0000_1111_0000_0;
        pat3 = 34'b0_1111_0000_1111_0000_1111_0000_1111_0000_0;

        // Reset state and quiet idle
        rst_n = 1'b0;
        applyStimulus(2'b00, 1'b1);
        #1;
        checkOutput("rst_led",   ledA,  2'b00);
        checkOutput("rst_busy",  busyA, 2'b00);
        checkOutput("rst_ledB",  ledB,  2'b11);
        #11;
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) tick();
        checkOutput("idle_led",  ledA,  2'b00);
        checkOutput("idle_busy", busyA, 2'b00);
        checkOutput("idle_ledB", ledB,  2'b11);

        // Single pulse on channel 0
        $display("[TB] single burst");
        for (int c = 0; c <= 17; c++) begin
            applyStimulus((c == 0) ? 2'b01 : 2'b00, 1'b1);
            checkOutput("burst_led",  ledA, {1'b0, pat2[c]});
            checkOutput("burst_ledB", ledB, ~{1'b0, pat2[c]});
            checkOutput("burst_busy", busyA, {1'b0, (c >= 1 && c <= 16)});
            tick();
        end

        // Several retriggers queue exactly one extra burst
        $display("[TB] retrigger");
        for (int c = 0; c <= 33; c++) begin
            applyStimulus((c == 0 || c == 2 || c == 6) ? 2'b01 : 2'b00, 1'b1);
            checkOutput("retrig_led",  ledA, {1'b0, pat3[c]});
            checkOutput("retrig_busy", busyA, {1'b0, (c >= 1 && c <= 32)});
            tick();
        end
        for (int c = 0; c < 8; c++) tick();
        checkOutput("retrig_done", busyA, 2'b00);

        // Held trigger on channel 1: continuous blinking
        $display("[TB] held trigger");
        for (int c = 0; c < 100; c++) begin
            applyStimulus(2'b10, 1'b1);
            bit1 = (c >= 1) && ((((c - 1) / 4) % 2) == 0);
            checkOutput("held_led",  ledA,  {bit1, 1'b0});
            checkOutput("held_busy", busyA, {(c >= 1), 1'b0});
            tick();
        end
        applyStimulus(2'b00, 1'b0);
        tick();
        checkOutput("held_clear", busyA, 2'b00);

        // Simultaneous triggers start together
        applyStimulus(2'b11, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b1);
        checkOutput("simul_led",  ledA,  2'b11);
        checkOutput("simul_busy", busyA, 2'b11);
        applyStimulus(2'b00, 1'b0);
        tick();
        checkOutput("simul_clear", busyA, 2'b00);

        // en=0 mid-ON drops the burst and the pending retrigger
        $display("[TB] enable drop");
        applyStimulus(2'b01, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b1);
        checkOutput("en_on1", ledA, 2'b01);
        tick();
        applyStimulus(2'b01, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b0);
        checkOutput("en_on3", ledA, 2'b01);
        tick();
        checkOutput("en_off_led",  ledA,  2'b00);
        checkOutput("en_off_busy", busyA, 2'b00);
        applyStimulus(2'b01, 1'b0);
        tick();
        checkOutput("en_ignore", busyA, 2'b00);
        applyStimulus(2'b00, 1'b1);
        for (int c = 0; c < 20; c++) tick();
        checkOutput("en_nopend", busyA, 2'b00);

        // Asynchronous reset in the middle of ON
        $display("[TB] async reset");
        applyStimulus(2'b01, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b1);
        tick();
        checkOutput("aon_led_pre", ledA, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("aon_led",  ledA,  2'b00);
        checkOutput("aon_ledB", ledB,  2'b11);
        checkOutput("aon_busy", busyA, 2'b00);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of OFF
        applyStimulus(2'b01, 1'b1);
        tick();
        applyStimulus(2'b00, 1'b1);
        for (int c = 0; c < 5; c++) tick();
        checkOutput("aoff_busy_pre", busyA, 2'b01);
        checkOutput("aoff_led_pre",  ledA,  2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("aoff_busy",  busyA, 2'b00);
        checkOutput("aoff_busyB", busyB, 2'b00);
        checkOutput("aoff_led",   ledA,  2'b00);
        checkOutput("aoff_ledB",  ledB,  2'b11);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("post_rst", busyA, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
